regfile_wb_scoreboard: RTL and testbench

//  Sequences access to the register file's single write port and tracks in-flight destination registers.

---
 rtl/regfile_wb_scoreboard_pkg.sv | 17 +
 rtl/regfile_wb_scoreboard_rr_arbiter2.sv | 32 +++
 rtl/regfile_wb_scoreboard.sv | 93 +++++++++
 tb/tb_regfile_wb_scoreboard.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_scoreboard_pkg.sv
// Shared sizing and requester identifiers for the register-file writeback scoreboard.
package regfile_wb_scoreboard_pkg;

   localparam int unsigned DEF_REG_ADDR_WIDTH = 4;
   localparam int unsigned DEF_DATA_WIDTH     = 16;
   localparam int unsigned DEF_NUM_REGS       = 16;

   localparam int unsigned RQ_ALU = 0;
   localparam int unsigned RQ_MEM = 1;

   // Which requester wins the next tie.
   typedef enum logic {
      PRIO_ALU = 1'b0,
      PRIO_MEM = 1'b1
   } rrPtr_t;

endpackage

// File: rtl/regfile_wb_scoreboard_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves away from whoever was just granted.
module rr_arbiter2
   import regfile_wb_scoreboard_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   rrPtr_t ptr;

   always_comb begin
      gnt = '0;
      if (req[RQ_ALU] && (!req[RQ_MEM] || ptr == PRIO_ALU)) begin
         gnt[RQ_ALU] = 1'b1;
      end else if (req[RQ_MEM]) begin
         gnt[RQ_MEM] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= PRIO_ALU;
      end else if (gnt[RQ_ALU]) begin
         ptr <= PRIO_MEM;
      end else if (gnt[RQ_MEM]) begin
         ptr <= PRIO_ALU;
      end
   end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Register-file write-port sequencer: arbitrates ALU/load writebacks and tracks
// pending destination registers to stall dependent issue.
module regfile_wb_scoreboard
   import regfile_wb_scoreboard_pkg::*;
#(
   parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int unsigned NUM_REGS       = DEF_NUM_REGS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      iss_valid,
   input  logic [REG_ADDR_WIDTH-1:0] iss_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] iss_rs2,
   input  logic [REG_ADDR_WIDTH-1:0] iss_rd,
   output logic                      iss_stall,
   input  logic                      alu_wb_valid,
   input  logic [REG_ADDR_WIDTH-1:0] alu_wb_rd,
   input  logic [DATA_WIDTH-1:0]     alu_wb_data,
   output logic                      alu_wb_ready,
   input  logic                      mem_wb_valid,
   input  logic [REG_ADDR_WIDTH-1:0] mem_wb_rd,
   input  logic [DATA_WIDTH-1:0]     mem_wb_data,
   output logic                      mem_wb_ready,
   output logic                      rf_we,
   output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0]     rf_wdata,
   output logic [NUM_REGS-1:0]       busy_vec,
   output logic                      err_unres
);

   logic [1:0]                req;
   logic [1:0]                gnt;
   logic                      anyGnt;
   logic [REG_ADDR_WIDTH-1:0] selRd;
   logic [DATA_WIDTH-1:0]     selData;
   logic [NUM_REGS-1:0]       setMask;
   logic [NUM_REGS-1:0]       clrMask;

   assign req[RQ_ALU] = alu_wb_valid;
   assign req[RQ_MEM] = mem_wb_valid;

   rr_arbiter2 uArb (
      .clk (clk),
      .rst (rst),
      .req (req),
      .gnt (gnt)
   );

   assign alu_wb_ready = gnt[RQ_ALU];
   assign mem_wb_ready = gnt[RQ_MEM];
   assign anyGnt       = |gnt;

   // busy[0] is never set, so rd=0 never contributes to a stall.
   assign iss_stall = iss_valid & (busy_vec[iss_rs1] | busy_vec[iss_rs2] | busy_vec[iss_rd]);

   always_comb begin
      selRd   = alu_wb_rd;
      selData = alu_wb_data;
      if (gnt[RQ_MEM]) begin
         selRd   = mem_wb_rd;
         selData = mem_wb_data;
      end
   end

   always_comb begin
      setMask = '0;
      clrMask = '0;
      if (iss_valid && !iss_stall && iss_rd != '0) setMask[iss_rd] = 1'b1;
      if (rf_we) clrMask[rf_waddr] = 1'b1;
   end

   // Clearing is driven by the registered write, so busy drops on the same
   // edge the register file captures the data.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_vec  <= '0;
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
         err_unres <= 1'b0;
      end else begin
         busy_vec <= (busy_vec & ~clrMask) | setMask;
         rf_we    <= anyGnt && selRd != '0;
         if (anyGnt && selRd != '0) begin
            rf_waddr <= selRd;
            rf_wdata <= selData;
            if (!busy_vec[selRd]) err_unres <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Bench for regfile_wb_scoreboard: directed scenarios then random traffic,
// every cycle compared against an array-based reference model.
module tb_regfile_wb_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        iss_valid;
   logic [3:0]  iss_rs1, iss_rs2, iss_rd;
   logic        iss_stall;
   logic        alu_wb_valid;
   logic [3:0]  alu_wb_rd;
   logic [15:0] alu_wb_data;
   logic        alu_wb_ready;
   logic        mem_wb_valid;
   logic [3:0]  mem_wb_rd;
   logic [15:0] mem_wb_data;
   logic        mem_wb_ready;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic [15:0] busy_vec;
   logic        err_unres;

   int checks = 0;
   int failures = 0;

   // Reference model state
   bit          mBusy[16];
   bit          mWe;
   logic [3:0]  mWaddr;
   logic [15:0] mWdata;
   bit          mErr;
   int          mLast;
   bit          mGntA, mGntM;

   regfile_wb_scoreboard #(
      .REG_ADDR_WIDTH (4),
      .DATA_WIDTH     (16),
      .NUM_REGS       (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .iss_valid    (iss_valid),
      .iss_rs1      (iss_rs1),
      .iss_rs2      (iss_rs2),
      .iss_rd       (iss_rd),
      .iss_stall    (iss_stall),
      .alu_wb_valid (alu_wb_valid),
      .alu_wb_rd    (alu_wb_rd),
      .alu_wb_data  (alu_wb_data),
      .alu_wb_ready (alu_wb_ready),
      .mem_wb_valid (mem_wb_valid),
      .mem_wb_rd    (mem_wb_rd),
      .mem_wb_data  (mem_wb_data),
      .mem_wb_ready (mem_wb_ready),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .busy_vec     (busy_vec),
      .err_unres    (err_unres)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      foreach (mBusy[i]) mBusy[i] = 1'b0;
      mWe = 1'b0; mWaddr = '0; mWdata = '0; mErr = 1'b0; mLast = 1;
   endtask

   // Compare every output against the model, advance the model, cross one edge.
   task automatic step();
      logic [15:0] expBusy;
      bit          eStall, gA, gM;
      bit          nb[16];
      logic [3:0]  wRd;
      logic [15:0] wData;
      #1;
      foreach (mBusy[i]) expBusy[i] = mBusy[i];
      eStall = iss_valid && (mBusy[iss_rs1] || mBusy[iss_rs2] || mBusy[iss_rd]);
      gA = alu_wb_valid && (!mem_wb_valid || mLast == 1);
      gM = mem_wb_valid && !gA;
      chk("iss_stall", {31'd0, iss_stall}, {31'd0, eStall});
      chk("alu_ready", {31'd0, alu_wb_ready}, {31'd0, gA});
      chk("mem_ready", {31'd0, mem_wb_ready}, {31'd0, gM});
      chk("rf_we", {31'd0, rf_we}, {31'd0, mWe});
      chk("rf_waddr", {28'd0, rf_waddr}, {28'd0, mWaddr});
      chk("rf_wdata", {16'd0, rf_wdata}, {16'd0, mWdata});
      chk("busy_vec", {16'd0, busy_vec}, {16'd0, expBusy});
      chk("err_unres", {31'd0, err_unres}, {31'd0, mErr});
      if (rst) begin
         modelReset();
      end else begin
         nb = mBusy;
         if (mWe) nb[mWaddr] = 1'b0;
         if (iss_valid && !eStall && iss_rd != 0) nb[iss_rd] = 1'b1;
         wRd = gA ? alu_wb_rd : mem_wb_rd;
         wData = gA ? alu_wb_data : mem_wb_data;
         if (gA || gM) begin
            if (wRd != 0 && !mBusy[wRd]) mErr = 1'b1;
            mLast = gA ? 0 : 1;
         end
         mWe = (gA || gM) && wRd != 0;
         if (mWe) begin
            mWaddr = wRd;
            mWdata = wData;
         end
         mBusy = nb;
      end
      mGntA = gA;
      mGntM = gM;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd);
      iss_valid = 1'b1; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd;
   endtask

   function automatic logic [3:0] pickRd();
      int unsigned r;
      r = $urandom_range(15, 0);
      if ($urandom_range(3, 0) != 0) begin
         for (int k = 0; k < 16; k++) begin
            if (mBusy[(r + k) % 16]) return 4'((r + k) % 16);
         end
      end
      return 4'(r);
   endfunction

   initial begin
      rst = 1'b1; iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
      alu_wb_valid = 1'b0; alu_wb_rd = '0; alu_wb_data = '0;
      mem_wb_valid = 1'b0; mem_wb_rd = '0; mem_wb_data = '0;
      @(posedge clk);
      #1;
      modelReset();
      step();
      rst = 1'b0;
      chk("reset_busy", {16'd0, busy_vec}, 32'h0);
      chk("reset_we", {31'd0, rf_we}, 32'h0);

      // Scenario 1: issue, dependent stall, writeback, release
      issue(0, 0, 3); step();
      iss_valid = 1'b0;
      chk("s1_busy_set", {16'd0, busy_vec}, 32'h0008);
      issue(3, 0, 0);
      #1 chk("s1_stall", {31'd0, iss_stall}, 32'h1);
      alu_wb_valid = 1'b1; alu_wb_rd = 4'd3; alu_wb_data = 16'h002A;
      step();
      alu_wb_valid = 1'b0;
      chk("s1_we", {31'd0, rf_we}, 32'h1);
      chk("s1_waddr", {28'd0, rf_waddr}, 32'h3);
      chk("s1_wdata", {16'd0, rf_wdata}, 32'h002A);
      step();
      chk("s1_busy_clr", {16'd0, busy_vec}, 32'h0);
      #1 chk("s1_unstall", {31'd0, iss_stall}, 32'h0);
      iss_valid = 1'b0;

      // Scenario 2: tie after reset, ALU then MEM
      rst = 1'b1; step(); rst = 1'b0;
      issue(0, 0, 1); step();
      issue(0, 0, 2); step();
      iss_valid = 1'b0;
      alu_wb_valid = 1'b1; alu_wb_rd = 4'd1; alu_wb_data = 16'h0011;
      mem_wb_valid = 1'b1; mem_wb_rd = 4'd2; mem_wb_data = 16'h0022;
      step();
      alu_wb_valid = 1'b0;
      chk("s2_first", {28'd0, rf_waddr}, 32'h1);
      step();
      mem_wb_valid = 1'b0;
      chk("s2_second", {28'd0, rf_waddr}, 32'h2);
      chk("s2_wdata", {16'd0, rf_wdata}, 32'h0022);
      step();

      // Scenario 3: writeback to r0
      mem_wb_valid = 1'b1; mem_wb_rd = 4'd0; mem_wb_data = 16'hFFFF;
      step();
      mem_wb_valid = 1'b0;
      chk("s3_no_we", {31'd0, rf_we}, 32'h0);
      chk("s3_no_err", {31'd0, err_unres}, 32'h0);

      // Scenario 4: unreserved writeback
      alu_wb_valid = 1'b1; alu_wb_rd = 4'd5; alu_wb_data = 16'h1234;
      step();
      alu_wb_valid = 1'b0;
      chk("s4_err", {31'd0, err_unres}, 32'h1);
      chk("s4_waddr", {28'd0, rf_waddr}, 32'h5);
      step(); step();
      chk("s4_err_sticky", {31'd0, err_unres}, 32'h1);

      // Scenario 5: reset mid-operation
      issue(0, 0, 1); step();
      issue(0, 0, 2); step();
      issue(0, 0, 5); step();
      issue(0, 0, 6); step();
      iss_valid = 1'b0;
      chk("s5_busy", {16'd0, busy_vec}, 32'h0066);
      alu_wb_valid = 1'b1; alu_wb_rd = 4'd1; alu_wb_data = 16'hBEEF;
      rst = 1'b1; step(); rst = 1'b0;
      alu_wb_valid = 1'b0;
      chk("s5_busy_rst", {16'd0, busy_vec}, 32'h0);
      chk("s5_err_rst", {31'd0, err_unres}, 32'h0);
      step();
      chk("s5_we_rst", {31'd0, rf_we}, 32'h0);
      alu_wb_valid = 1'b1; alu_wb_rd = 4'd0;
      mem_wb_valid = 1'b1; mem_wb_rd = 4'd0;
      #1 chk("s5_alu_tie", {30'd0, alu_wb_ready, mem_wb_ready}, 32'h2);
      step();
      alu_wb_valid = 1'b0;
      step();
      mem_wb_valid = 1'b0;

      // Scenario 6: set and clear of different registers on one edge
      issue(0, 0, 4); step();
      iss_valid = 1'b0;
      alu_wb_valid = 1'b1; alu_wb_rd = 4'd4; alu_wb_data = 16'h4444;
      step();
      alu_wb_valid = 1'b0;
      chk("s6_busy_pre", {16'd0, busy_vec}, 32'h0010);
      issue(0, 0, 7); step();
      iss_valid = 1'b0;
      chk("s6_busy_post", {16'd0, busy_vec}, 32'h0080);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         rst = ($urandom_range(63, 0) == 0);
         iss_valid = 1'($urandom_range(1, 0));
         iss_rs1 = 4'($urandom_range(15, 0));
         iss_rs2 = 4'($urandom_range(15, 0));
         iss_rd = 4'($urandom_range(15, 0));
         if (!alu_wb_valid && $urandom_range(1, 0) == 1) begin
            alu_wb_valid = 1'b1; alu_wb_rd = pickRd(); alu_wb_data = 16'($urandom);
         end
         if (!mem_wb_valid && $urandom_range(1, 0) == 1) begin
            mem_wb_valid = 1'b1; mem_wb_rd = pickRd(); mem_wb_data = 16'($urandom);
         end
         step();
         if (mGntA) alu_wb_valid = 1'b0;
         if (mGntM) mem_wb_valid = 1'b0;
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
